// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller with blanking gaps and frame-synchronous
// double buffering of the displayed hex word.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        lz_supp,
    output logic [0:6]  SSeg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [3:0]       an_q, an_d;
    logic [0:6]       sseg_q, sseg_d;
    logic             frame_tick_q, frame_tick_d;

    logic [3:0]       nibble;
    logic             suppress;
    logic             boundary;

    // Segment patterns are listed a..g, so the literal MSB lands on SSeg[0] = a.
    function automatic logic [0:6] decode(input logic [3:0] nib);
        logic [0:6] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // A digit is suppressed only if it and every more-significant nibble are zero.
    always_comb begin
        nibble   = disp_q[{idx_q, 2'b00} +: 4];
        suppress = 1'b0;
        if (lz_supp) begin
            case (idx_q)
                2'd3:    suppress = (disp_q[15:12] == 4'h0);
                2'd2:    suppress = (disp_q[15:8] == 8'h00);
                2'd1:    suppress = (disp_q[15:4] == 12'h000);
                default: suppress = 1'b0;
            endcase
        end
        boundary = en && (state_q == SHOW) && (cnt_q == CNT_LAST) && (idx_q == 2'd3);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        an_d         = 4'hF;
        sseg_d       = 7'b1111111;
        frame_tick_d = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
            if (load) begin
                disp_d = data_in;
                pend_d = 1'b0;
            end
        end else begin
            if (state_q == IDLE) begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end else begin
                if (state_q == SHOW) begin
                    an_d   = ~(4'b0001 << idx_q);
                    sseg_d = suppress ? 7'b1111111 : decode(nibble);
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = BLANK;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_d >= CNT_BLANK) ? SHOW : BLANK;
                end
            end

            // A load on the boundary itself wins over any pending shadow value.
            if (boundary) begin
                frame_tick_d = 1'b1;
                if (load) begin
                    disp_d = data_in;
                end else if (pend_q) begin
                    disp_d = shadow_q;
                end
                pend_d = 1'b0;
            end else if (load) begin
                shadow_d = data_in;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            shadow_q     <= 16'h0000;
            pend_q       <= 1'b0;
            an_q         <= 4'hF;
            sseg_q       <= 7'b1111111;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign SSeg       = sseg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
